// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX/RX state encodings and helper functions.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    // Rounded clocks per oversample tick, never below 1.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        int unsigned d;
        d = (clk_freq + 8 * baud) / (16 * baud);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        case (mode)
            PAR_ODD:  return ~(^data);
            PAR_EVEN: return ^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversample tick generator; clr holds the phase at zero so a frame starts bit-aligned.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 20_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic hclk,
    input  logic rst,
    input  logic clr,
    output logic tick16
);

    localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick16 = !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_core_cfg.sv
// Configurable UART: independent TX and RX engines, 16x oversampling, optional parity.
module uart_core_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 20_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int          DATA_BITS = 8,
    parameter int          PARITY    = 0,
    parameter int          STOP_BITS = 1
) (
    input  logic                 hclk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2);
    localparam bit         HAS_PAR   = (PARITY != PAR_NONE);

    tx_state_e            tx_state_q;
    logic [3:0]           tx_tick_q;
    logic [2:0]           tx_bit_q;
    logic                 tx_stop_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q;
    logic                 tx_q;
    logic                 tx_busy_q;
    logic                 tx_idle;
    logic                 tx_tick16;

    rx_state_e            rx_state_q;
    logic [1:0]           rx_sync_q;
    logic                 rx_prev_q;
    logic                 rx_s;
    logic [3:0]           rx_tick_q;
    logic [2:0]           rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_bad_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_ready_q;
    logic                 rx_ferr_q;
    logic                 rx_perr_q;
    logic                 rx_idle;
    logic                 rx_tick16;

    assign tx_idle = (tx_state_q == TX_IDLE);
    assign rx_idle = (rx_state_q == RX_IDLE);
    assign rx_s    = rx_sync_q[1];

    // Each engine owns a divider, restarted while idle, so bit timing is frame-aligned.
    uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx_baud (
        .hclk(hclk), .rst(rst), .clr(tx_idle), .tick16(tx_tick16)
    );

    uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx_baud (
        .hclk(hclk), .rst(rst), .clr(rx_idle), .tick16(rx_tick16)
    );

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else if (tx_state_q == TX_IDLE) begin
            if (tx_start) begin
                tx_shift_q <= tx_data;
                tx_par_q   <= parity_bit(8'(tx_data), PARITY);
                tx_tick_q  <= '0;
                tx_q       <= 1'b0;
                tx_busy_q  <= 1'b1;
                tx_state_q <= TX_START;
            end
        end else if (tx_tick16) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
                case (tx_state_q)
                    TX_START: begin
                        tx_state_q <= TX_DATA;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= '0;
                    end
                    TX_DATA: begin
                        if (tx_bit_q == LAST_BIT) begin
                            if (HAS_PAR) begin
                                tx_state_q <= TX_PARITY;
                                tx_q       <= tx_par_q;
                            end else begin
                                tx_state_q <= TX_STOP;
                                tx_q       <= 1'b1;
                                tx_stop_q  <= 1'b0;
                            end
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end
                    TX_PARITY: begin
                        tx_state_q <= TX_STOP;
                        tx_q       <= 1'b1;
                        tx_stop_q  <= 1'b0;
                    end
                    TX_STOP: begin
                        if (tx_stop_q == LAST_STOP) begin
                            tx_state_q <= TX_IDLE;
                            tx_busy_q  <= 1'b0;
                        end else begin
                            tx_stop_q <= 1'b1;
                        end
                    end
                    default: tx_state_q <= TX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            rx_sync_q    <= '1;
            rx_prev_q    <= 1'b1;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_bad_q <= 1'b0;
            rx_data_q    <= '0;
            rx_ready_q   <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_perr_q    <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx};
            rx_prev_q  <= rx_s;
            rx_ready_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        rx_state_q   <= RX_START;
                        rx_tick_q    <= '0;
                        rx_par_bad_q <= 1'b0;
                    end
                end
                // Break/line-low keeps restarting the high-time count.
                RX_WAIT_IDLE: begin
                    if (!rx_s) begin
                        rx_tick_q <= '0;
                    end else if (rx_tick16) begin
                        rx_tick_q <= rx_tick_q + 4'd1;
                        if (rx_tick_q == 4'd15) rx_state_q <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_tick16) begin
                        rx_tick_q <= rx_tick_q + 4'd1;
                        if (rx_tick_q == 4'd7) begin
                            rx_tick_q <= '0;
                            rx_bit_q  <= '0;
                            if (rx_s) rx_state_q <= RX_IDLE;
                            else      rx_state_q <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick16) begin
                        rx_tick_q <= rx_tick_q + 4'd1;
                        if (rx_tick_q == 4'd15) begin
                            rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                            if (rx_bit_q != LAST_BIT) rx_bit_q <= rx_bit_q + 3'd1;
                            else if (HAS_PAR)         rx_state_q <= RX_PARITY;
                            else                      rx_state_q <= RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_tick16) begin
                        rx_tick_q <= rx_tick_q + 4'd1;
                        if (rx_tick_q == 4'd15) begin
                            rx_par_bad_q <= rx_s ^ parity_bit(8'(rx_shift_q), PARITY);
                            rx_state_q   <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick16) begin
                        rx_tick_q <= rx_tick_q + 4'd1;
                        if (rx_tick_q == 4'd15) begin
                            rx_data_q  <= rx_shift_q;
                            rx_ferr_q  <= !rx_s;
                            rx_perr_q  <= rx_par_bad_q;
                            rx_ready_q <= 1'b1;
                            if (rx_s) rx_state_q <= RX_IDLE;
                            else      rx_state_q <= RX_WAIT_IDLE;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign tx            = tx_q;
    assign tx_busy       = tx_busy_q;
    assign rx_data       = rx_data_q;
    assign rx_ready      = rx_ready_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Scoreboard bench: instance A (8E1, bench-driven rx) and instance B (7O2, tx looped to rx).
module tb_uart_core_cfg;

    localparam int unsigned CLK = 3_200_000;
    localparam int unsigned BD  = 100_000;
    localparam int          BIT = 32;

    logic hclk = 1'b0;
    logic rst  = 1'b1;
    always #5 hclk = ~hclk;

    logic       rx_a, tx_a, tx_start_a, tx_busy_a, rx_ready_a, rx_frame_err_a, rx_parity_err_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       rx_b, tx_b, tx_start_b, tx_busy_b, rx_ready_b, rx_frame_err_b, rx_parity_err_b;
    logic [6:0] tx_data_b, rx_data_b;

    assign rx_b = tx_b;

    uart_core_cfg #(.CLK_FREQ(CLK), .BAUD(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_a (
        .hclk(hclk), .rst(rst), .rx(rx_a), .tx(tx_a), .tx_data(tx_data_a), .tx_start(tx_start_a),
        .tx_busy(tx_busy_a), .rx_data(rx_data_a), .rx_ready(rx_ready_a),
        .rx_frame_err(rx_frame_err_a), .rx_parity_err(rx_parity_err_a)
    );

    uart_core_cfg #(.CLK_FREQ(CLK), .BAUD(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
        .hclk(hclk), .rst(rst), .rx(rx_b), .tx(tx_b), .tx_data(tx_data_b), .tx_start(tx_start_b),
        .tx_busy(tx_busy_b), .rx_data(rx_data_b), .rx_ready(rx_ready_b),
        .rx_frame_err(rx_frame_err_b), .rx_parity_err(rx_parity_err_b)
    );

    int checks = 0;
    int errors = 0;

    logic [10:0] txa_q[$];
    logic [9:0]  rxa_q[$];
    logic [8:0]  rxb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Line image of an 8E1 frame, index 0 is the first bit on the wire.
    function automatic logic [10:0] frame_8e1(input logic [7:0] d, input logic stopb, input bit badpar);
        logic par;
        par = (($countones(d) % 2) == 1) ^ badpar;
        return {stopb, par, d, 1'b0};
    endfunction

    task automatic wait_idle_a();
        for (int i = 0; i < 2000 && tx_busy_a; i++) @(negedge hclk);
        check("txa_idle_wait", tx_busy_a, 0);
    endtask

    task automatic wait_idle_b();
        for (int i = 0; i < 2000 && tx_busy_b; i++) @(negedge hclk);
        check("txb_idle_wait", tx_busy_b, 0);
    endtask

    task automatic send_a(input logic [7:0] d);
        wait_idle_a();
        tx_data_a  = d;
        tx_start_a = 1'b1;
        txa_q.push_back(frame_8e1(d, 1'b1, 1'b0));
        @(negedge hclk);
        tx_start_a = 1'b0;
    endtask

    task automatic send_b(input logic [6:0] d);
        wait_idle_b();
        tx_data_b  = d;
        tx_start_b = 1'b1;
        rxb_q.push_back({d, 2'b00});
        @(negedge hclk);
        tx_start_b = 1'b0;
    endtask

    task automatic drive_a_rx(input logic [7:0] d, input bit badpar, input logic stopb, input bit expect_it);
        logic [10:0] f;
        f = frame_8e1(d, stopb, badpar);
        if (expect_it) rxa_q.push_back({d, ~stopb, badpar});
        for (int i = 0; i < 11; i++) begin
            rx_a = f[i];
            repeat (BIT) @(negedge hclk);
        end
        rx_a = 1'b1;
    endtask

    // TX line monitor for A: decodes mid-bit samples and measures busy length.
    initial begin
        logic [10:0] got, e;
        int n;
        bit aborted;
        forever begin
            @(negedge hclk);
            if (!rst && tx_busy_a) begin
                got = '0;
                n = 1;
                aborted = 0;
                for (int i = 1; i < 400; i++) begin
                    @(negedge hclk);
                    if (rst) begin
                        aborted = 1;
                        break;
                    end
                    if ((i % BIT) == 16 && i < 352) got[i / BIT] = tx_a;
                    if (tx_busy_a) n++;
                    else break;
                end
                if (txa_q.size() == 0) begin
                    check("txa_unexpected_frame", got, 11'h7FF);
                end else begin
                    e = txa_q.pop_front();
                    if (!aborted) begin
                        check("txa_frame_bits", got, e);
                        check("txa_busy_cycles", n, 352);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge hclk);
            if (rx_ready_a) begin
                if (rxa_q.size() == 0) begin
                    check("rxa_unexpected_ready", rx_ready_a, 0);
                end else begin
                    logic [9:0] e;
                    e = rxa_q.pop_front();
                    check("rxa_data", rx_data_a, e[9:2]);
                    check("rxa_frame_err", rx_frame_err_a, e[1]);
                    check("rxa_parity_err", rx_parity_err_a, e[0]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge hclk);
            if (rx_ready_b) begin
                if (rxb_q.size() == 0) begin
                    check("rxb_unexpected_ready", rx_ready_b, 0);
                end else begin
                    logic [8:0] e;
                    e = rxb_q.pop_front();
                    check("rxb_data", rx_data_b, e[8:2]);
                    check("rxb_frame_err", rx_frame_err_b, e[1]);
                    check("rxb_parity_err", rx_parity_err_b, e[0]);
                end
            end
        end
    end

    initial begin
        int lowcnt;
        rx_a = 1'b1;
        tx_start_a = 1'b0;
        tx_data_a  = '0;
        tx_start_b = 1'b0;
        tx_data_b  = '0;
        rst = 1'b1;
        repeat (5) @(negedge hclk);

        check("rst_tx_a", tx_a, 1);
        check("rst_busy_a", tx_busy_a, 0);
        check("rst_rx_data_a", rx_data_a, 0);
        check("rst_rx_ready_a", rx_ready_a, 0);
        check("rst_ferr_a", rx_frame_err_a, 0);
        check("rst_perr_a", rx_parity_err_a, 0);
        check("rst_tx_b", tx_b, 1);
        check("rst_busy_b", tx_busy_b, 0);
        check("rst_rx_data_b", rx_data_b, 0);
        check("rst_rx_ready_b", rx_ready_b, 0);
        check("rst_ferr_b", rx_frame_err_b, 0);
        check("rst_perr_b", rx_parity_err_b, 0);

        rst = 1'b0;
        repeat (10) @(negedge hclk);

        // TX-A, RX-A and the B loopback all run at once.
        fork
            begin
                send_a(8'hA5);
                for (int i = 0; i < 4; i++) send_a(8'($urandom));
                wait_idle_a();
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    drive_a_rx(8'($urandom), ($urandom % 3) == 0, 1'b1, 1);
                    repeat (2 * BIT) @(negedge hclk);
                end
            end
            begin
                send_b(7'h55);
                for (int i = 0; i < 4; i++) send_b(7'($urandom));
                wait_idle_b();
            end
        join

        // Second tx_start in mid-frame must be ignored.
        send_a(8'h3C);
        repeat (100) @(negedge hclk);
        tx_data_a  = 8'hFF;
        tx_start_a = 1'b1;
        @(negedge hclk);
        tx_start_a = 1'b0;
        wait_idle_a();
        repeat (20) @(negedge hclk);

        // Frame error, then a frame arriving before 16 high ticks must be dropped.
        drive_a_rx(8'h3C, 0, 1'b0, 1);
        repeat (12) @(negedge hclk);
        drive_a_rx(8'h00, 0, 1'b1, 0);
        repeat (2 * BIT) @(negedge hclk);
        drive_a_rx(8'($urandom), 0, 1'b1, 1);
        repeat (2 * BIT) @(negedge hclk);

        // Short glitch must not produce a frame; the next real frame must.
        rx_a = 1'b0;
        repeat (4) @(negedge hclk);
        rx_a = 1'b1;
        repeat (3 * BIT) @(negedge hclk);
        drive_a_rx(8'h81, 1, 1'b1, 1);
        repeat (2 * BIT) @(negedge hclk);

        for (int i = 0; i < 2000 && (rxa_q.size() + rxb_q.size() + txa_q.size()) != 0; i++)
            @(negedge hclk);

        // Reset in the middle of the TX data bits.
        send_a(8'h96);
        repeat (150) @(negedge hclk);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_a", tx_a, 1);
        check("midrst_busy_a", tx_busy_a, 0);
        check("midrst_rx_data_a", rx_data_a, 0);
        check("midrst_ferr_a", rx_frame_err_a, 0);
        repeat (3) @(negedge hclk);
        rst = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge hclk);
            if (!tx_a || tx_busy_a) lowcnt++;
        end
        check("postrst_tx_quiet", lowcnt, 0);

        check("txa_queue_empty", txa_q.size(), 0);
        check("rxa_queue_empty", rxa_q.size(), 0);
        check("rxb_queue_empty", rxb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_core_cfg.md
UART_CORE_CFG -- requirements
Module: uart_core_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 20_000_000, meaning the hclk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning the payload width; legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0=none, 1=odd, 2=even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning TX stop bits; legal values 1 or 2.
REQ-006 SHALL have port hclk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port rx, input, 1 bit: asynchronous serial receive line, idle high.
REQ-009 SHALL have port tx, output, 1 bit: serial transmit line, idle high.
REQ-010 SHALL have port tx_data, input, DATA_BITS bits: the byte to send.
REQ-011 SHALL have port tx_start, input, 1 bit: request to send, sampled each hclk.
REQ-012 SHALL have port tx_busy, output, 1 bit: transmitter occupied.
REQ-013 SHALL have port rx_data, output, DATA_BITS bits: last received payload.
REQ-014 SHALL have port rx_ready, output, 1 bit: one-hclk pulse per completed RX frame.
REQ-015 SHALL have port rx_frame_err, output, 1 bit: stop bit of the last frame sampled low.
REQ-016 SHALL have port rx_parity_err, output, 1 bit: parity mismatch on the last frame; always 0 when PARITY=0.

Function
REQ-017 SHALL derive the 16x-oversample tick from hclk with divisor DIV = CLK_FREQ/(16*BAUD), integer-rounded, minimum 1; the tick is a one-hclk pulse every DIV cycles.
REQ-018 SHALL use 16 ticks per bit period for both TX and RX.
REQ-019 TX FSM SHALL use the states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-020 SHALL accept tx_start only in IDLE with tx_busy=0; on acceptance SHALL latch tx_data and assert tx_busy on the next hclk.
REQ-021 SHALL ignore tx_start while tx_busy=1, leaving the in-flight frame unaffected.
REQ-022 TX SHALL send in this order: a start bit (0), the data LSB-first, the parity bit (if enabled), then STOP_BITS stop bits (1); each bit lasts 16 ticks.
REQ-023 SHALL deassert tx_busy in the hclk after the last stop bit completes; back-to-back tx_start SHALL be accepted then.
REQ-024 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-025 RX FSM SHALL use the states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-026 In IDLE, a synchronized high-to-low transition on rx SHALL enter START; at tick 8, a high line SHALL return to IDLE with no flags (false start).
REQ-027 After a valid start, RX SHALL sample each following bit every 16 ticks (mid-bit).
REQ-028 SHALL check only one RX stop bit regardless of STOP_BITS.
REQ-029 At the stop sample, SHALL update rx_data, rx_frame_err and rx_parity_err, and pulse rx_ready for exactly one hclk; this happens on every frame, including errored ones.
REQ-030 Error flags and rx_data SHALL hold until the next rx_ready pulse.
REQ-031 On a frame error (including a break), RX SHALL enter WAIT_IDLE and re-arm only after the synchronized rx has been high for 16 ticks.
REQ-032 TX and RX SHALL operate fully independently and simultaneously.

Reset
REQ-033 While rst=1: tx=1, tx_busy=0, rx_data=0, rx_ready=0, rx_frame_err=0, rx_parity_err=0; both FSMs in IDLE; the divider, tick and bit counters and the synchronizer (set high) cleared.
REQ-034 Reset asserted mid-frame SHALL force tx high immediately and abandon both frames; no rx_ready pulse SHALL follow.

Structure
REQ-035 SHALL place the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the TX/RX state encodings in a shared package, uart_pkg.
REQ-036 SHALL place the oversample tick generator in one sub-module, uart_baud_gen, with parameters CLK_FREQ and BAUD and output tick16.

Verification (CLK_FREQ=3_200_000, BAUD=100_000, giving DIV=2 and 32 hclk per bit)
REQ-037 PARITY=2, send 0xA5 -> tx waveform 0,1,0,1,0,0,1,0,1,0(parity),1, with 32 hclk per bit; tx_busy high for 352 hclk.
REQ-038 Loop tx to rx, DATA_BITS=7, PARITY=1, send 0x55 -> rx_data=0x55, rx_ready pulses once, both error flags 0.
REQ-039 Drive an rx frame with 0x3C and stop bit 0 -> rx_ready pulse, rx_frame_err=1, rx_data=0x3C; no new frame is accepted until rx has been high for 16 ticks.
REQ-040 Apply a 4-hclk low glitch on idle rx -> no rx_ready pulse, RX FSM back in IDLE.
REQ-041 Pulse tx_start again during a frame with tx_data=0xFF -> the first frame is unchanged; the second pulse is ignored.
REQ-042 Assert rst halfway through the TX data bits -> tx=1 and tx_busy=0 within the same hclk, with no glitch after release.
